pixel_stream_arbiter: RTL and testbench

//   Shares the single pixel output stream (x_out/y_out/color_out) between N_REQ tile

---
 rtl/pixel_stream_arbiter.sv | 135 +++++++++++++
 tb/tb_pixel_stream_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_arbiter.sv
// ============================================================================
// Module      : pixel_stream_arbiter
// Description : Round-robin arbiter that merges N_REQ tile-renderer pixel
//               streams into one registered output stage. It also counts the
//               pixels handed downstream and pulses frame_done at frame end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_stream_arbiter #(
    parameter int N_REQ  = 4,
    parameter int X_W    = 11,
    parameter int Y_W    = 12,
    parameter int C_W    = 32,
    parameter int X_LAST = 1079,
    parameter int Y_LAST = 2159,
    parameter int CNT_W  = 22
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*X_W-1:0]       req_x,
    input  logic [N_REQ*Y_W-1:0]       req_y,
    input  logic [N_REQ*C_W-1:0]       req_color,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [X_W-1:0]             x_out,
    output logic [Y_W-1:0]             y_out,
    output logic [C_W-1:0]             color_out,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic [CNT_W-1:0]           pix_count,
    output logic                       frame_done
);

    localparam int              c_id_w    = $clog2(N_REQ);
    localparam logic [c_id_w-1:0] c_last_id = c_id_w'(N_REQ - 1);

    logic [c_id_w-1:0] r_rr_ptr;
    logic [c_id_w-1:0] r_grant_id;
    logic              r_out_valid;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [C_W-1:0]    r_color;
    logic [CNT_W-1:0]  r_pix_count;
    logic              r_frame_done;

    logic              w_found;
    logic [c_id_w-1:0] w_winner;
    logic [c_id_w-1:0] w_next_ptr;
    logic              w_load_en;
    logic              w_accept;
    logic              w_handshake;
    logic              w_last_pix;
    logic [N_REQ-1:0]  w_onehot;

    // Scan requesters starting at the round-robin pointer; first hit wins.
    always_comb begin : p_arb
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = c_id_w'(idx);
            end
        end
    end

    assign w_load_en   = !r_out_valid || out_ready;
    assign w_accept    = w_found && w_load_en;
    assign w_handshake = r_out_valid && out_ready;
    assign w_last_pix  = (r_x == X_W'(X_LAST)) && (r_y == Y_W'(Y_LAST));
    assign w_next_ptr  = (w_winner == c_last_id) ? '0 : w_winner + 1'b1;
    assign w_onehot    = w_found ? (N_REQ'(1) << w_winner) : '0;

    // Gated by rst_n so no requester sees an accept while reset is held.
    assign req_ready   = (rst_n && w_load_en) ? w_onehot : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_color     <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_rr_ptr    <= w_next_ptr;
                r_grant_id  <= w_winner;
                r_x         <= req_x[w_winner*X_W +: X_W];
                r_y         <= req_y[w_winner*Y_W +: Y_W];
                r_color     <= req_color[w_winner*C_W +: C_W];
            end else if (w_handshake) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Frame counter: clears on the final coordinate, otherwise saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_count  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_handshake) begin
                if (w_last_pix) begin
                    r_pix_count  <= '0;
                    r_frame_done <= 1'b1;
                end else if (r_pix_count != '1) begin
                    r_pix_count <= r_pix_count + 1'b1;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign x_out      = r_x;
    assign y_out      = r_y;
    assign color_out  = r_color;
    assign grant_id   = r_grant_id;
    assign pix_count  = r_pix_count;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_pixel_stream_arbiter.sv
// ============================================================================
// Module      : tb_pixel_stream_arbiter
// Description : Directed self-checking bench for pixel_stream_arbiter using a
//               reduced 8x4 frame and a 6-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_stream_arbiter;

    localparam int N_REQ  = 4;
    localparam int X_W    = 11;
    localparam int Y_W    = 12;
    localparam int C_W    = 32;
    localparam int X_LAST = 7;
    localparam int Y_LAST = 3;
    localparam int CNT_W  = 6;
    localparam int NPIX   = (X_LAST + 1) * (Y_LAST + 1);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*X_W-1:0]   req_x;
    logic [N_REQ*Y_W-1:0]   req_y;
    logic [N_REQ*C_W-1:0]   req_color;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [X_W-1:0]         x_out;
    logic [Y_W-1:0]         y_out;
    logic [C_W-1:0]         color_out;
    logic [1:0]             grant_id;
    logic [CNT_W-1:0]       pix_count;
    logic                   frame_done;

    int checks   = 0;
    int failures = 0;

    pixel_stream_arbiter #(
        .N_REQ (N_REQ), .X_W(X_W), .Y_W(Y_W), .C_W(C_W),
        .X_LAST(X_LAST), .Y_LAST(Y_LAST), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_color (req_color),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .color_out (color_out),
        .grant_id  (grant_id),
        .pix_count (pix_count),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int x, input int y, input logic [31:0] c);
        req_x[i*X_W +: X_W]     = X_W'(x);
        req_y[i*Y_W +: Y_W]     = Y_W'(y);
        req_color[i*C_W +: C_W] = c;
    endtask

    task automatic set_default;
        for (int i = 0; i < N_REQ; i++) begin
            set_req(i, 10 + i, 20 + i, 32'hC0DE_0000 + 32'(i));
        end
    endtask

    initial begin : stim
        int          nxt [N_REQ];
        bit          seen [NPIX];
        int          pulses, exp_cnt, nseen, hx, hy, pidx;
        logic [3:0]  acc;
        logic        hs, hlast;
        logic [31:0] hc;
        bit          fin;

        // Reset state, with requests asserted to prove req_ready is gated
        rst_n     = 1'b0;
        out_ready = 1'b0;
        req_valid = 4'hF;
        req_x     = '0;
        req_y     = '0;
        req_color = '0;
        set_default();
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_color", color_out, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_cnt", pix_count, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ready", req_ready, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;

        // Round robin: eight grants 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            chk("rr_ready", req_ready, 4'b0001 << (k % 4));
            tick();
            chk("rr_valid", out_valid, 1);
            chk("rr_grant", grant_id, k % 4);
            chk("rr_x", x_out, 10 + (k % 4));
            chk("rr_color", color_out, 32'hC0DE_0000 + 32'(k % 4));
        end
        req_valid = 4'h0;
        #1;
        chk("drain_ready", req_ready, 0);
        tick();
        chk("rr_count", pix_count, 8);
        chk("drain_valid", out_valid, 0);
        chk("drain_x_hold", x_out, 13);
        chk("drain_y_hold", y_out, 23);

        // Backpressure: three frozen cycles, then resume at pointer 1
        out_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("bp_first_ready", req_ready, 4'b0001);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready", req_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_grant", grant_id, 0);
            chk("bp_x", x_out, 10);
            chk("bp_color", color_out, 32'hC0DE_0000);
            chk("bp_cnt", pix_count, 8);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_ready", req_ready, 4'b0010);
        tick();
        req_valid = 4'h0;
        chk("bp_resume_grant", grant_id, 1);
        chk("bp_resume_x", x_out, 11);
        chk("bp_resume_cnt", pix_count, 9);
        tick();
        chk("bp_drain_cnt", pix_count, 10);
        chk("bp_drain_valid", out_valid, 0);

        // Saturation: 60 more handshakes take the count from 10 past 63
        req_valid = 4'hF;
        for (int k = 0; k < 60; k++) begin
            tick();
        end
        req_valid = 4'h0;
        tick();
        chk("sat_cnt", pix_count, 63);
        chk("sat_done", frame_done, 0);

        // Reset asserted mid-cycle with a pixel in the output stage
        out_ready = 1'b0;
        req_valid = 4'hF;
        tick();
        chk("mr_loaded", out_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_cnt", pix_count, 0);
        chk("mr_done", frame_done, 0);
        chk("mr_ready", req_ready, 0);
        chk("mr_x", x_out, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mr_first_grant", req_ready, 4'b0001);
        req_valid = 4'h0;
        tick();
        chk("mr_idle_done", frame_done, 0);

        // Full reduced frame from four interleaved sources, random out_ready
        for (int i = 0; i < N_REQ; i++) nxt[i] = i;
        for (int p = 0; p < NPIX; p++) seen[p] = 1'b0;
        pulses  = 0;
        exp_cnt = 0;
        fin     = 1'b0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (nxt[i] < NPIX) begin
                    req_valid[i] = 1'b1;
                    set_req(i, nxt[i] % 8, nxt[i] / 8, 32'hA000_0000 | 32'(nxt[i]));
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc   = req_ready;
            hs    = out_valid && out_ready;
            hx    = int'(x_out);
            hy    = int'(y_out);
            hc    = color_out;
            hlast = hs && (hx == X_LAST) && (hy == Y_LAST);
            if (hs) begin
                chk("frame_range", (hx <= X_LAST) && (hy <= Y_LAST), 1);
                chk("frame_color", hc, 32'hA000_0000 | 32'(hy * 8 + hx));
                if (hx <= X_LAST && hy <= Y_LAST) begin
                    pidx = hy * 8 + hx;
                    chk("frame_dup", seen[pidx], 0);
                    seen[pidx] = 1'b1;
                end
            end
            if (hlast) chk("cnt_before_last", pix_count, NPIX - 1);
            tick();
            for (int i = 0; i < N_REQ; i++) begin
                if (acc[i]) nxt[i] += 4;
            end
            if (hs) exp_cnt = hlast ? 0 : exp_cnt + 1;
            chk("frame_done", frame_done, hlast);
            chk("frame_cnt", pix_count, exp_cnt);
            if (frame_done) pulses++;
            fin = (nxt[0] >= NPIX) && (nxt[1] >= NPIX) && (nxt[2] >= NPIX)
                  && (nxt[3] >= NPIX) && !out_valid;
        end
        nseen = 0;
        for (int p = 0; p < NPIX; p++) nseen += int'(seen[p]);
        chk("frame_finished", fin, 1);
        chk("frame_pulses", pulses, 1);
        chk("frame_seen", nseen, NPIX);
        chk("frame_cnt_after", pix_count, 0);

        // Single source then idle drain
        out_ready = 1'b1;
        req_valid = 4'b0100;
        set_req(2, 5, 7, 32'hFF00_FF00);
        #1;
        chk("single_ready", req_ready, 4'b0100);
        tick();
        req_valid = 4'h0;
        chk("single_valid", out_valid, 1);
        chk("single_x", x_out, 5);
        chk("single_y", y_out, 7);
        chk("single_color", color_out, 32'hFF00_FF00);
        chk("single_grant", grant_id, 2);
        tick();
        chk("idle_valid", out_valid, 0);
        chk("idle_x_hold", x_out, 5);
        chk("idle_y_hold", y_out, 7);
        chk("idle_cnt", pix_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
